// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the bit-serial adder.
//   state_e       - controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand/sum width in bits
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// full_adder: one-bit combinational full adder.
//   a, b, cin - input bits
//   sum       - a ^ b ^ cin
//   cout      - majority(a, b, cin)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder with valid/ready handshakes.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - operand handshake (accepted only in IDLE)
//   a, b                - WIDTH-bit operands, captured on acceptance
//   out_valid, out_ready- result handshake (result held in DONE)
//   sum, carry_out      - last completed result, qualified by out_valid
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Counter must be able to hold WIDTH itself: the count runs 0..WIDTH.
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_sum;
    logic fa_cout;

    // Operands are shifted right each step, so bit 0 is always the current bit.
    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != LAST) begin
                    // Sum bits enter at the MSB; after WIDTH steps bit 0 is the LSB.
                    acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
                    carry_d = fa_cout;
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    // Publish only here so sum/carry_out hold the previous
                    // result throughout RUN.
                    sum_d   = acc_q;
                    cout_d  = carry_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule : serial_adder
